fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the in-order RISC-V pipeline, sitting in front of the fetch stage and driving the fetch-to-decode boundary. It owns the program counter and issues one instruction-memory request at a time over a valid/ready handshake. It buffers the returned instruction in a single-entry output register presented to decode with valid/ready. A redirect from a later stage (branch/jump/exception) replaces the PC and squashes in-flight and buffered work.

---
 rtl/fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_fetch_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time and
// holds the returned instruction in a one-entry buffer for decode.
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            io_imem_req_valid,
    input  logic            io_imem_req_ready,
    output logic [XLEN-1:0] io_imem_req_addr,
    input  logic            io_imem_resp_valid,
    input  logic [XLEN-1:0] io_imem_resp_data,
    input  logic            io_redirect_valid,
    input  logic [XLEN-1:0] io_redirect_pc,
    output logic            io_id_valid,
    input  logic            io_id_ready,
    output logic [XLEN-1:0] io_id_inst,
    output logic [XLEN-1:0] io_id_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_IDLE = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic            kill;
    logic            buf_valid;
    logic [XLEN-1:0] buf_inst;
    logic [XLEN-1:0] buf_pc;

    logic [XLEN-1:0] redirect_target;
    logic            drain;
    logic            unused_redirect_bits;

    assign redirect_target      = {io_redirect_pc[XLEN-1:2], 2'b00};
    assign drain                = buf_valid & io_id_ready;
    assign unused_redirect_bits = ^io_redirect_pc[1:0];

    // req_addr is latched on entry to REQ so an unaccepted request keeps its
    // address even when a redirect moves pc underneath it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            kill      <= 1'b0;
            buf_valid <= 1'b0;
            buf_inst  <= '0;
            buf_pc    <= '0;
        end else begin
            if (drain) begin
                buf_valid <= 1'b0;
            end
            if (io_redirect_valid) begin
                pc        <= redirect_target;
                buf_valid <= 1'b0;
                case (state)
                    S_REQ: begin
                        kill <= 1'b1;
                        if (io_imem_req_ready) begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (io_imem_resp_valid) begin
                            kill     <= 1'b0;
                            state    <= S_REQ;
                            req_addr <= redirect_target;
                        end else begin
                            kill <= 1'b1;
                        end
                    end
                    S_IDLE: begin
                        state    <= S_REQ;
                        req_addr <= redirect_target;
                    end
                    default: begin
                        state    <= S_REQ;
                        req_addr <= redirect_target;
                    end
                endcase
            end else begin
                case (state)
                    S_REQ: begin
                        if (io_imem_req_ready) begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (io_imem_resp_valid) begin
                            if (kill) begin
                                kill     <= 1'b0;
                                state    <= S_REQ;
                                req_addr <= pc;
                            end else begin
                                buf_valid <= 1'b1;
                                buf_inst  <= io_imem_resp_data;
                                buf_pc    <= req_addr;
                                pc        <= req_addr + XLEN'(4);
                                state     <= S_IDLE;
                            end
                        end
                    end
                    S_IDLE: begin
                        if (!buf_valid || drain) begin
                            state    <= S_REQ;
                            req_addr <= pc;
                        end
                    end
                    default: begin
                        state    <= S_REQ;
                        req_addr <= pc;
                    end
                endcase
            end
        end
    end

    // Reset masks the request so nothing is issued while the FSM is being cleared.
    assign io_imem_req_valid = (state == S_REQ) && !reset;
    assign io_imem_req_addr  = req_addr;
    assign io_id_valid       = buf_valid;
    assign io_id_inst        = buf_inst;
    assign io_id_pc          = buf_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl: each task drives one scenario and checks
// the expected cycle-by-cycle behaviour inline.
module tb_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int errors = 0;
    int checks = 0;

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_imem_req_valid  (req_valid),
        .io_imem_req_ready  (req_ready),
        .io_imem_req_addr   (req_addr),
        .io_imem_resp_valid (resp_valid),
        .io_imem_resp_data  (resp_data),
        .io_redirect_valid  (redirect_valid),
        .io_redirect_pc     (redirect_pc),
        .io_id_valid        (id_valid),
        .io_id_ready        (id_ready),
        .io_id_inst         (id_inst),
        .io_id_pc           (id_pc)
    );

    always #5 clock = ~clock;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Hold reset two cycles, then release; returns in the first cycle after release.
    task automatic do_reset();
        reset          = 1'b1;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_data      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // From REQ with req_ready=1 and id_ready=1: one full fetch, ending in the next REQ.
    task automatic fetch_one(input logic [31:0] data);
        tick();
        resp_valid = 1'b1;
        resp_data  = data;
        tick();
        resp_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_valid: got %b expected 0", id_valid); end
        checks++; if (id_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_id_inst: got %h expected 00000000", id_inst); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_id_pc: got %h expected 00000000", id_pc); end
        checks++; if (req_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_req_addr: got %h expected 00000000", req_addr); end
        reset = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_req_valid: got %b expected 1", req_valid); end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        req_ready = 1'b1;
        id_ready  = 1'b1;
        checks++; if (req_addr !== 32'h0) begin errors++; $display("[TB] FAIL basic_c0_addr: got %h expected 00000000", req_addr); end
        tick();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_c1_req_valid: got %b expected 0", req_valid); end
        resp_valid = 1'b1;
        resp_data  = 32'h0000_0013;
        tick();
        resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_c2_id_valid: got %b expected 1", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL basic_c2_id_pc: got %h expected 00000000", id_pc); end
        checks++; if (id_inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL basic_c2_id_inst: got %h expected 00000013", id_inst); end
        tick();
        checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_c3_req_valid: got %b expected 1", req_valid); end
        checks++; if (req_addr !== 32'h4) begin errors++; $display("[TB] FAIL basic_c3_req_addr: got %h expected 00000004", req_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_c3_id_valid: got %b expected 0", id_valid); end
        tick();
        resp_valid = 1'b1;
        resp_data  = 32'h0010_0093;
        tick();
        resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_c5_id_valid: got %b expected 1", id_valid); end
        checks++; if (id_pc !== 32'h4) begin errors++; $display("[TB] FAIL basic_c5_id_pc: got %h expected 00000004", id_pc); end
        checks++; if (id_inst !== 32'h0010_0093) begin errors++; $display("[TB] FAIL basic_c5_id_inst: got %h expected 00100093", id_inst); end
        tick();
        checks++; if (req_addr !== 32'h8) begin errors++; $display("[TB] FAIL basic_c6_req_addr: got %h expected 00000008", req_addr); end
    endtask

    task automatic test_decode_stall();
        do_reset();
        req_ready = 1'b1;
        id_ready  = 1'b0;
        tick();
        resp_valid = 1'b1;
        resp_data  = 32'h0050_0113;
        tick();
        resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_id_valid[%0d]: got %b expected 1", i, id_valid); end
            checks++; if (id_inst !== 32'h0050_0113) begin errors++; $display("[TB] FAIL stall_id_inst[%0d]: got %h expected 00500113", i, id_inst); end
            checks++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL stall_id_pc[%0d]: got %h expected 00000000", i, id_pc); end
            checks++; if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_valid[%0d]: got %b expected 0", i, req_valid); end
            tick();
        end
        id_ready = 1'b1;
        tick();
        checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_req_valid: got %b expected 1", req_valid); end
        checks++; if (req_addr !== 32'h4) begin errors++; $display("[TB] FAIL stall_release_req_addr: got %h expected 00000004", req_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release_id_valid: got %b expected 0", id_valid); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        req_ready = 1'b1;
        id_ready  = 1'b1;
        fetch_one(32'h0000_0013);
        fetch_one(32'h0000_0013);
        checks++; if (req_addr !== 32'h8) begin errors++; $display("[TB] FAIL rwait_req_addr: got %h expected 00000008", req_addr); end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        resp_valid     = 1'b1;
        resp_data      = 32'hDEAD_BEEF;
        tick();
        resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rwait_dropped_id_valid: got %b expected 0", id_valid); end
        checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rwait_new_req_valid: got %b expected 1", req_valid); end
        checks++; if (req_addr !== 32'h100) begin errors++; $display("[TB] FAIL rwait_new_req_addr: got %h expected 00000100", req_addr); end
        tick();
        resp_valid = 1'b1;
        resp_data  = 32'h0000_0013;
        tick();
        resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL rwait_decode_valid: got %b expected 1", id_valid); end
        checks++; if (id_pc !== 32'h100) begin errors++; $display("[TB] FAIL rwait_decode_pc: got %h expected 00000100", id_pc); end
    endtask

    task automatic test_redirect_idle();
        do_reset();
        req_ready = 1'b1;
        id_ready  = 1'b0;
        tick();
        resp_valid = 1'b1;
        resp_data  = 32'h0000_0013;
        tick();
        resp_valid     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL ridle_req_valid: got %b expected 1", req_valid); end
        checks++; if (req_addr !== 32'h200) begin errors++; $display("[TB] FAIL ridle_req_addr: got %h expected 00000200", req_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL ridle_flush_id_valid: got %b expected 0", id_valid); end
    endtask

    task automatic test_redirect_req();
        do_reset();
        req_ready = 1'b1;
        id_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_one(32'h0000_0013);
        end
        checks++; if (req_addr !== 32'h10) begin errors++; $display("[TB] FAIL rreq_start_addr: got %h expected 00000010", req_addr); end
        req_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rreq_hold_valid[%0d]: got %b expected 1", i, req_valid); end
            checks++; if (req_addr !== 32'h10) begin errors++; $display("[TB] FAIL rreq_hold_addr[%0d]: got %h expected 00000010", i, req_addr); end
            tick();
        end
        req_ready = 1'b1;
        checks++; if (req_addr !== 32'h10) begin errors++; $display("[TB] FAIL rreq_accept_addr: got %h expected 00000010", req_addr); end
        tick();
        resp_valid = 1'b1;
        resp_data  = 32'h0BAD_0BAD;
        tick();
        resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rreq_dropped_id_valid: got %b expected 0", id_valid); end
        checks++; if (req_addr !== 32'h40) begin errors++; $display("[TB] FAIL rreq_new_addr: got %h expected 00000040", req_addr); end
        tick();
        resp_valid = 1'b1;
        resp_data  = 32'h0000_0513;
        tick();
        resp_valid = 1'b0;
        checks++; if (id_pc !== 32'h40) begin errors++; $display("[TB] FAIL rreq_decode_pc: got %h expected 00000040", id_pc); end
        checks++; if (id_inst !== 32'h0000_0513) begin errors++; $display("[TB] FAIL rreq_decode_inst: got %h expected 00000513", id_inst); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_ready = 1'b1;
        id_ready  = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_req_valid: got %b expected 0", req_valid); end
        tick();
        reset     = 1'b0;
        req_ready = 1'b0;
        #1;
        checks++; if (req_addr !== 32'h0) begin errors++; $display("[TB] FAIL midreset_req_addr: got %h expected 00000000", req_addr); end
        tick();
        resp_valid = 1'b1;
        resp_data  = 32'h0BAD_F00D;
        tick();
        resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stale_id_valid: got %b expected 0", id_valid); end
        checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL midreset_still_req: got %b expected 1", req_valid); end
        req_ready = 1'b1;
        tick();
        resp_valid = 1'b1;
        resp_data  = 32'h0000_0013;
        tick();
        resp_valid = 1'b0;
        checks++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL midreset_new_id_valid: got %b expected 1", id_valid); end
        checks++; if (id_inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL midreset_new_id_inst: got %h expected 00000013", id_inst); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL midreset_new_id_pc: got %h expected 00000000", id_pc); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_decode_stall();
        test_redirect_wait();
        test_redirect_idle();
        test_redirect_req();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
